// File: rtl/rtc_bus_pkg.sv
// Shared constants for the RTC multiplexed AD bus: strobe encodings, bit positions
// and the write-sequencer phase enum. The read sequencer is expected to import these too.
package rtc_bus_pkg;

    localparam int CNT_W = 6;

    // control = {cs_n, a_d, rd_n, wr_n}
    localparam int CS_BIT = 3;
    localparam int AD_BIT = 2;
    localparam int RD_BIT = 1;
    localparam int WR_BIT = 0;

    localparam logic [3:0] CTRL_IDLE     = 4'b1111;
    localparam logic [3:0] CTRL_A_SETUP  = 4'b0011;
    localparam logic [3:0] CTRL_A_STROBE = 4'b0010;
    localparam logic [3:0] CTRL_D_SETUP  = 4'b0111;
    localparam logic [3:0] CTRL_D_STROBE = 4'b0110;

    // Encoding order matters: the phase sequence is walked by incrementing the state.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_A_SETUP  = 4'd1,
        ST_A_STROBE = 4'd2,
        ST_A_HOLD   = 4'd3,
        ST_GAP      = 4'd4,
        ST_D_SETUP  = 4'd5,
        ST_D_STROBE = 4'd6,
        ST_D_HOLD   = 4'd7,
        ST_DONE     = 4'd8
    } rtc_wr_state_t;

endpackage

// File: rtl/rtc_bus_phase_timer.sv
// Loadable down-counter timing one bus phase; expire is high in the phase's last cycle.
module rtc_bus_phase_timer
    import rtc_bus_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/rtc_write_ctrl.sv
// Write sequencer for the RTC AD bus: address cycle, idle gap, data cycle, done pulse.
// All bus outputs are registered from the next-state decode.
module rtc_write_ctrl
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 6,
    parameter int T_HOLD   = 2,
    parameter int T_GAP    = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       bus_grant,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [3:0] control,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       busy,
    output logic       done
);

    rtc_wr_state_t    state, state_next;
    logic [7:0]       addr_q, data_q, addr_src;
    logic             accept, expire, load;
    logic [CNT_W-1:0] load_val;
    logic [3:0]       ctrl_d;
    logic [7:0]       ad_d;
    logic             oe_d, busy_d, done_d;

    function automatic int phase_len(rtc_wr_state_t s);
        case (s)
            ST_A_SETUP, ST_D_SETUP:   return T_SETUP;
            ST_A_STROBE, ST_D_STROBE: return T_STROBE;
            ST_A_HOLD, ST_D_HOLD:     return T_HOLD;
            ST_GAP:                   return T_GAP;
            default:                  return 1;
        endcase
    endfunction

    // First phase at or after s with a nonzero length; zero-length phases cost no cycle.
    function automatic rtc_wr_state_t skip_from(rtc_wr_state_t s);
        rtc_wr_state_t r = s;
        for (int i = 0; i < 8; i++) begin
            if (r != ST_DONE && phase_len(r) == 0) r = rtc_wr_state_t'(r + 4'd1);
        end
        return r;
    endfunction

    assign accept = (state == ST_IDLE) && start && bus_grant;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = skip_from(ST_A_SETUP);
            ST_DONE: state_next = ST_IDLE;
            default: if (expire) state_next = skip_from(rtc_wr_state_t'(state + 4'd1));
        endcase
    end

    assign load     = (state_next != state);
    assign load_val = CNT_W'(phase_len(state_next) - 1);

    rtc_bus_phase_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    // On the accept edge the address latch is not yet loaded, so drive straight from the input.
    assign addr_src = accept ? wr_addr : addr_q;

    always_comb begin
        ctrl_d = CTRL_IDLE;
        ad_d   = '0;
        oe_d   = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_next)
            ST_A_SETUP, ST_A_HOLD: begin
                ctrl_d = CTRL_A_SETUP;  ad_d = addr_src; oe_d = 1'b1; busy_d = 1'b1;
            end
            ST_A_STROBE: begin
                ctrl_d = CTRL_A_STROBE; ad_d = addr_src; oe_d = 1'b1; busy_d = 1'b1;
            end
            ST_GAP: busy_d = 1'b1;
            ST_D_SETUP, ST_D_HOLD: begin
                ctrl_d = CTRL_D_SETUP;  ad_d = data_q;   oe_d = 1'b1; busy_d = 1'b1;
            end
            ST_D_STROBE: begin
                ctrl_d = CTRL_D_STROBE; ad_d = data_q;   oe_d = 1'b1; busy_d = 1'b1;
            end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            control <= CTRL_IDLE;
            ad_out  <= '0;
            ad_oe   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            if (accept) begin
                addr_q <= wr_addr;
                data_q <= wr_data;
            end
            control <= ctrl_d;
            ad_out  <= ad_d;
            ad_oe   <= oe_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_rtc_write_ctrl.sv
// Bench for rtc_write_ctrl: default-timing and all-zero-phase instances share stimulus;
// a transaction-level model predicts every cycle, directed checks pin key points.
module tb_rtc_write_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic bus_grant = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [1:0][3:0] control;
    logic [1:0][7:0] ad_out;
    logic [1:0] ad_oe, busy, done;

    int n_tot = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rtc_write_ctrl u_dflt (
        .clk(clk), .reset(reset), .start(start), .bus_grant(bus_grant),
        .wr_addr(wr_addr), .wr_data(wr_data), .control(control[0]),
        .ad_out(ad_out[0]), .ad_oe(ad_oe[0]), .busy(busy[0]), .done(done[0])
    );

    rtc_write_ctrl #(.T_SETUP(0), .T_STROBE(1), .T_HOLD(0), .T_GAP(0)) u_zero (
        .clk(clk), .reset(reset), .start(start), .bus_grant(bus_grant),
        .wr_addr(wr_addr), .wr_data(wr_data), .control(control[1]),
        .ad_out(ad_out[1]), .ad_oe(ad_oe[1]), .busy(busy[1]), .done(done[1])
    );

    // ---------------- model ----------------
    typedef struct packed {
        logic [3:0] c;
        logic [7:0] a;
        logic       oe;
        logic       bsy;
        logic       dn;
    } exp_t;

    function automatic int p_su(int d); return d == 0 ? 2 : 0; endfunction
    function automatic int p_st(int d); return d == 0 ? 6 : 1; endfunction
    function automatic int p_ho(int d); return d == 0 ? 2 : 0; endfunction
    function automatic int p_gp(int d); return d == 0 ? 12 : 0; endfunction
    function automatic int p_total(int d);
        return 2 * (p_su(d) + p_st(d) + p_ho(d)) + p_gp(d);
    endfunction

    // Expected outputs k cycles after the accept edge (k=0: idle).
    function automatic exp_t sched(int d, int k, logic [7:0] a, logic [7:0] dt);
        exp_t r;
        int su, st, l, gp, j;
        su = p_su(d); st = p_st(d); gp = p_gp(d);
        l = su + st + p_ho(d);
        r.c = 4'b1111; r.a = 8'h00; r.oe = 1'b0; r.bsy = 1'b0; r.dn = 1'b0;
        if (k >= 1 && k <= 2 * l + gp) r.bsy = 1'b1;
        if (k >= 1 && k <= l) begin
            j = k; r.oe = 1'b1; r.a = a;
            r.c = (j <= su || j > su + st) ? 4'b0011 : 4'b0010;
        end else if (k > l + gp && k <= 2 * l + gp) begin
            j = k - l - gp; r.oe = 1'b1; r.a = dt;
            r.c = (j <= su || j > su + st) ? 4'b0111 : 4'b0110;
        end else if (k == 2 * l + gp + 1) begin
            r.dn = 1'b1;
        end
        return r;
    endfunction

    int k_m[2];
    logic [7:0] la_m[2];
    logic [7:0] ld_m[2];

    initial begin
        k_m[0] = 0; k_m[1] = 0;
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) k_m[d] = 0;
            else if (k_m[d] != 0 && k_m[d] <= p_total(d)) k_m[d] = k_m[d] + 1;
            else if (k_m[d] == p_total(d) + 1) k_m[d] = 0;
            else if (start && bus_grant) begin
                k_m[d] = 1; la_m[d] = wr_addr; ld_m[d] = wr_data;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                exp_t e;
                e = sched(d, k_m[d], la_m[d], ld_m[d]);
                n_tot++;
                if (control[d] !== e.c || ad_oe[d] !== e.oe || busy[d] !== e.bsy ||
                    done[d] !== e.dn || (e.oe && ad_out[d] !== e.a)) begin
                    n_bad++;
                    $display("FAIL model[%0d] t=%0t got ctrl=%b oe=%b ad=%h busy=%b done=%b, want ctrl=%b oe=%b ad=%h busy=%b done=%b",
                             d, $time, control[d], ad_oe[d], ad_out[d], busy[d], done[d],
                             e.c, e.oe, e.a, e.bsy, e.dn);
                end
            end
        end
    end

    // ---------------- directed ----------------
    int cyc;

    task automatic lit(input string n, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", n, got, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
        cyc += n;
    endtask

    initial begin
        int cnt, cnt2, seen;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        lit("rst_ctrl", 32'(control[0]), 32'(4'b1111));
        lit("rst_oe",   32'(ad_oe[0]),   32'(0));
        lit("rst_ad",   32'(ad_out[0]),  32'(0));
        lit("rst_busy", 32'(busy[0]),    32'(0));
        reset = 1'b1;
        adv(2);

        // basic write on both instances
        wr_addr = 8'h21; wr_data = 8'h59; start = 1'b1; bus_grant = 1'b1;
        cyc = 0; adv(1);
        start = 1'b0;
        lit("c1_ctrl", 32'(control[0]), 32'(4'b0011));
        lit("c1_ad",   32'(ad_out[0]),  32'(8'h21));
        lit("c1_busy", 32'(busy[0]),    32'(1));
        lit("z1_ctrl", 32'(control[1]), 32'(4'b0010));
        adv(1);
        lit("z2_ctrl", 32'(control[1]), 32'(4'b0110));
        lit("z2_ad",   32'(ad_out[1]),  32'(8'h59));
        adv(1);
        lit("z3_done", 32'(done[1]),    32'(1));
        lit("c3_ctrl", 32'(control[0]), 32'(4'b0010));
        adv(8);
        lit("c11_ctrl", 32'(control[0]), 32'(4'b1111));
        lit("c11_oe",   32'(ad_oe[0]),   32'(0));
        adv(12);
        lit("c23_ctrl", 32'(control[0]), 32'(4'b0111));
        lit("c23_ad",   32'(ad_out[0]),  32'(8'h59));
        adv(2);
        lit("c25_ctrl", 32'(control[0]), 32'(4'b0110));
        adv(6);
        lit("c31_ctrl", 32'(control[0]), 32'(4'b0111));
        adv(2);
        lit("c33_done", 32'(done[0]), 32'(1));
        lit("c33_busy", 32'(busy[0]), 32'(0));
        adv(3);

        // reset in the middle of a write
        wr_addr = 8'h44; wr_data = 8'h55; start = 1'b1;
        cyc = 0; adv(1);
        start = 1'b0;
        adv(14);
        reset = 1'b0;
        adv(1);
        lit("mrst_ctrl", 32'(control[0]), 32'(4'b1111));
        lit("mrst_oe",   32'(ad_oe[0]),   32'(0));
        lit("mrst_busy", 32'(busy[0]),    32'(0));
        lit("mrst_done", 32'(done[0]),    32'(0));
        adv(2);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            adv(1);
            if (control[0][0] == 1'b0) cnt++;
        end
        lit("mrst_no_strobe", cnt, 0);

        // arbitration: request held while bus not granted
        wr_addr = 8'h10; wr_data = 8'h20; start = 1'b1; bus_grant = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            adv(1);
            if (control[0] != 4'b1111 || control[1] != 4'b1111) cnt++;
        end
        lit("arb_quiet", cnt, 0);
        bus_grant = 1'b1;
        adv(1);
        start = 1'b0;
        lit("arb_setup", 32'(control[0]), 32'(4'b0011));
        lit("arb_ad",    32'(ad_out[0]),  32'(8'h10));
        adv(40);

        // new request and data while busy are ignored
        wr_addr = 8'h22; wr_data = 8'h30; start = 1'b1;
        cnt = 0; cnt2 = 0;
        for (int c = 1; c <= 45; c++) begin
            adv(1);
            start = 1'b0;
            if (c == 12) begin
                wr_addr = 8'hFF; wr_data = 8'hEE; start = 1'b1;
            end
            if (done[0]) cnt++;
            if (ad_oe[0] && ad_out[0] != 8'h22 && ad_out[0] != 8'h30) cnt2++;
        end
        start = 1'b0;
        lit("busy_one_done", cnt, 1);
        lit("busy_bus_vals", cnt2, 0);
        adv(5);

        // back-to-back with start held; values swapped at done
        wr_addr = 8'hA1; wr_data = 8'hB1; start = 1'b1;
        seen = 0; cnt = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            adv(1);
            if (control[0][1] != 1'b1) cnt++;
            if (done[0]) seen = 1;
        end
        lit("b2b_done_seen", seen, 1);
        wr_addr = 8'hB1; wr_data = 8'hA1;
        adv(1);
        lit("b2b_gap_idle", 32'(control[0]), 32'(4'b1111));
        adv(1);
        lit("b2b_setup", 32'(control[0]), 32'(4'b0011));
        lit("b2b_ad",    32'(ad_out[0]),  32'(8'hB1));
        for (int i = 0; i < 40; i++) begin
            adv(1);
            if (control[0][1] != 1'b1 || control[1][1] != 1'b1) cnt++;
            if (i == 5) start = 1'b0;
        end
        lit("b2b_rd_n", cnt, 0);
        adv(5);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
